// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand request and result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             borrow;
  logic             ovf;
  modport master (output start, a, b, input busy, done, d, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, d, borrow, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with borrow and signed overflow flags
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d;
  logic             diff, bout;
  // operands shift right so the bit under test is always at index 0
  assign diff = a_q[0] ^ b_q[0] ^ bin_q;
  assign bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
  // next-state: accept in IDLE, one bit per CALC edge, publish results on the last bit
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CALC;
        a_d     = bus.a;
        b_d     = bus.b;
        a_msb_d = bus.a[WIDTH-1];
        b_msb_d = bus.b[WIDTH-1];
        cnt_d   = '0;
        bin_d   = 1'b0;
      end
      CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {diff, res_q[WIDTH-1:1]};
        bin_d = bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          d_d      = {diff, res_q[WIDTH-1:1]};
          borrow_d = bout;
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so a mid-run reset leaves no partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end
  assign bus.busy   = state_q != IDLE;
  assign bus.done   = state_q == DONE;
  assign bus.d      = d_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
endmodule
